// File: rtl/axi4_lite_pkg.sv
// Types shared by the AXI4-Lite write stage and register file: response codes,
// read FSM state encoding and an index-width helper.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  // One-hot read FSM states.
  typedef logic [2:0] rd_state_t;
  localparam rd_state_t ST_IDLE = 3'b001;
  localparam rd_state_t ST_READ = 3'b010;
  localparam rd_state_t ST_RESP = 3'b100;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// DEPTH x DATA_SIZE register storage with a byte-enable write port,
// a combinational read port and a flat image of all registers.
module axi4_lite_reg_bank
  import axi4_lite_pkg::*;
#(
  parameter  int unsigned DEPTH     = 4,
  parameter  int unsigned DATA_SIZE = 32,
  localparam int unsigned BYTES     = DATA_SIZE / 8,
  localparam int unsigned IDX_W     = idx_width(DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_clk_i,
  input  logic [DATA_SIZE-1:0]       wr_data_i,
  input  logic [IDX_W-1:0]           wr_idx_i,
  input  logic [BYTES-1:0]           wr_en_i,
  input  logic [IDX_W-1:0]           rd_idx_i,
  output logic [DATA_SIZE-1:0]       rd_data_o,
  output logic [DEPTH*DATA_SIZE-1:0] image_o
);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [DATA_SIZE-1:0] mem_d [DEPTH];

  // Out-of-range indices leave every register untouched.
  always_comb begin
    mem_d = mem_q;
    if (32'(wr_idx_i) < DEPTH) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (wr_en_i[b]) begin
          mem_d[wr_idx_i][8*b +: 8] = wr_data_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_clk_i) begin
    if (rst_clk_i) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_o = (32'(rd_idx_i) < DEPTH) ? mem_q[rd_idx_i] : '0;

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_image
    assign image_o[k*DATA_SIZE +: DATA_SIZE] = mem_q[k];
  end

endmodule

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite register file: commits write-stage commands into the register bank and
// serves AR/R reads through a three-state read FSM (one read outstanding at most).
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter  int unsigned DEPTH     = 4,
  parameter  int unsigned DATA_SIZE = 32,
  localparam int unsigned BYTES     = DATA_SIZE / 8,
  localparam int unsigned IDX_W     = idx_width(DEPTH),
  localparam int unsigned OFF_W     = $clog2(BYTES),
  localparam int unsigned ADDR_W    = IDX_W + OFF_W
) (
  input  logic                       clk_i,
  input  logic                       rst_clk_i,
  input  logic [DATA_SIZE-1:0]       register_data_i,
  input  logic [IDX_W-1:0]           register_address_i,
  input  logic [BYTES-1:0]           enable_register_data_i,
  input  logic [ADDR_W-1:0]          read_address_i,
  input  logic                       read_address_valid_i,
  output logic                       read_address_ready_o,
  output logic [DATA_SIZE-1:0]       read_data_o,
  output logic [1:0]                 read_response_o,
  output logic                       read_data_valid_o,
  input  logic                       read_data_ready_i,
  output logic [DEPTH*DATA_SIZE-1:0] registers_o
);

  rd_state_t            state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;
  resp_e                resp_q, resp_d;
  logic [DATA_SIZE-1:0] bank_rdata;

  axi4_lite_reg_bank #(
    .DEPTH     (DEPTH),
    .DATA_SIZE (DATA_SIZE)
  ) u_bank (
    .clk_i     (clk_i),
    .rst_clk_i (rst_clk_i),
    .wr_data_i (register_data_i),
    .wr_idx_i  (register_address_i),
    .wr_en_i   (enable_register_data_i),
    .rd_idx_i  (idx_q),
    .rd_data_o (bank_rdata),
    .image_o   (registers_o)
  );

  always_ff @(posedge clk_i or posedge rst_clk_i) begin
    if (rst_clk_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  // The READ cycle samples the bank before any same-edge write lands (no bypass).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (read_address_valid_i) begin
          idx_d   = read_address_i[ADDR_W-1:OFF_W];
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (32'(idx_q) < DEPTH) begin
          rdata_d = bank_rdata;
          resp_d  = RESP_OKAY;
        end else begin
          rdata_d = '0;
          resp_d  = RESP_DECERR;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (read_data_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign read_address_ready_o = (state_q == ST_IDLE) && !rst_clk_i;
  assign read_data_valid_o    = (state_q == ST_RESP);
  assign read_data_o          = rdata_q;
  assign read_response_o      = resp_q;

  // Read addresses must be word aligned; a write command is a single-cycle pulse.
  assert property (@(posedge clk_i) disable iff (rst_clk_i)
    read_address_valid_i |-> (read_address_i[OFF_W-1:0] == '0))
    else $error("axi4_lite_regfile: unaligned read address %0h", read_address_i);

  assert property (@(posedge clk_i) disable iff (rst_clk_i)
    (enable_register_data_i != '0) |=>
      !((enable_register_data_i != '0) && (register_address_i == $past(register_address_i))))
    else $warning("axi4_lite_regfile: write enable held for more than one cycle");

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Self-checking bench for axi4_lite_regfile (DEPTH=3 so index 3 is out of range).
module tb_axi4_lite_regfile;

  localparam int unsigned DEPTH = 3;
  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 2;
  localparam int unsigned AW    = 4;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  DECERR = 2'b11;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [DW-1:0]         wdata = '0;
  logic [IW-1:0]         widx = '0;
  logic [3:0]            wen = '0;
  logic [AW-1:0]         ar_addr = '0;
  logic                  ar_valid = 1'b0;
  logic                  ar_ready;
  logic [DW-1:0]         rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready = 1'b0;
  logic [DEPTH*DW-1:0]   regs;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] model [DEPTH];

  axi4_lite_regfile #(.DEPTH(DEPTH), .DATA_SIZE(DW)) dut (
    .clk_i                  (clk),
    .rst_clk_i              (rst),
    .register_data_i        (wdata),
    .register_address_i     (widx),
    .enable_register_data_i (wen),
    .read_address_i         (ar_addr),
    .read_address_valid_i   (ar_valid),
    .read_address_ready_o   (ar_ready),
    .read_data_o            (rdata),
    .read_response_o        (rresp),
    .read_data_valid_o      (rvalid),
    .read_data_ready_i      (rready),
    .registers_o            (regs)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [IW-1:0]       idx;
    logic [DW-1:0]       data;
    logic [3:0]          en;
    logic [DEPTH*DW-1:0] exp_image;
  } wvec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DEPTH*DW-1:0] model_image();
    logic [DEPTH*DW-1:0] img;
    for (int k = 0; k < int'(DEPTH); k++) img[k*DW +: DW] = model[k];
    return img;
  endfunction

  task automatic model_write(input int idx, input logic [DW-1:0] d, input logic [3:0] en);
    if (idx < int'(DEPTH))
      for (int b = 0; b < 4; b++)
        if (en[b]) model[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  // Single-cycle write pulse; checked one cycle after the commit edge.
  task automatic do_write(input logic [IW-1:0] idx, input logic [DW-1:0] d, input logic [3:0] en);
    @(negedge clk);
    widx = idx; wdata = d; wen = en;
    @(negedge clk);
    wen = '0;
    @(negedge clk);
  endtask

  // Full AR/R transaction; lat counts cycles from the AR handshake cycle to R valid.
  task automatic do_read(input logic [AW-1:0] addr, input int stall,
                         output logic [DW-1:0] d, output logic [1:0] r, output int lat);
    int guard;
    @(negedge clk);
    ar_addr = addr; ar_valid = 1'b1; rready = (stall == 0);
    guard = 0;
    while (!ar_ready && guard < 20) begin @(negedge clk); guard++; end
    chk("ar_ready", 128'(ar_ready), 128'(1));
    @(posedge clk);
    #1 ar_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
    d = rdata; r = rresp;
    if (stall > 0) begin
      ar_addr = '0; ar_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("r_hold", {rvalid, ar_ready, rresp, rdata}, {1'b1, 1'b0, r, d});
      end
      ar_valid = 1'b0; rready = 1'b1;
    end
    @(posedge clk);
    #1 rready = 1'b0;
    @(negedge clk);
    chk("r_done", {rvalid, ar_ready}, {1'b0, 1'b1});
  endtask

  initial begin
    wvec_t wv[7];
    logic [DW-1:0] d;
    logic [1:0] r;
    int lat;
    logic [DW-1:0] old2;

    wv[0] = '{2'd0, 32'h000000A5, 4'b0001, {32'h0,        32'h0,        32'h000000A5}};
    wv[1] = '{2'd1, 32'h11223344, 4'b1111, {32'h0,        32'h11223344, 32'h000000A5}};
    wv[2] = '{2'd1, 32'hAABBCCDD, 4'b0101, {32'h0,        32'h11BB33DD, 32'h000000A5}};
    wv[3] = '{2'd3, 32'hFFFFFFFF, 4'b1111, {32'h0,        32'h11BB33DD, 32'h000000A5}};
    wv[4] = '{2'd2, 32'hCAFEF00D, 4'b1100, {32'hCAFE0000, 32'h11BB33DD, 32'h000000A5}};
    wv[5] = '{2'd2, 32'h12345678, 4'b0000, {32'hCAFE0000, 32'h11BB33DD, 32'h000000A5}};
    wv[6] = '{2'd0, 32'h5A5A5A5A, 4'b1010, {32'hCAFE0000, 32'h11BB33DD, 32'h5A005AA5}};

    // Reset state
    #12;
    chk("rst_outputs", {ar_ready, rvalid, rresp, rdata}, '0);
    chk("rst_regs", 128'(regs), '0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 128'(ar_ready), 128'(1));

    // Table-driven writes
    foreach (wv[i]) begin
      do_write(wv[i].idx, wv[i].data, wv[i].en);
      chk($sformatf("write_vec%0d", i), 128'(regs), 128'(wv[i].exp_image));
    end
    for (int k = 0; k < int'(DEPTH); k++) model[k] = wv[6].exp_image[k*DW +: DW];

    // Latency, DECERR and backpressure
    do_read(4'd4, 0, d, r, lat);
    chk("lat_reg1", {32'(lat), r, d}, {32'd2, OKAY, 32'h11BB33DD});
    do_read(4'd12, 0, d, r, lat);
    chk("decerr", {r, d}, {DECERR, 32'h0});
    do_read(4'd0, 5, d, r, lat);
    chk("bp_reg0", {r, d}, {OKAY, 32'h5A005AA5});

    // Collision: write lands on the READ-cycle edge
    old2 = model[2];
    @(negedge clk);
    ar_addr = 4'd8; ar_valid = 1'b1; rready = 1'b0;
    @(posedge clk);
    #1 ar_valid = 1'b0;
    widx = 2'd2; wdata = 32'hDEADBEEF; wen = 4'b1111;
    @(posedge clk);
    #1 wen = '0;
    model_write(2, 32'hDEADBEEF, 4'b1111);
    @(negedge clk);
    chk("coll_data", {rvalid, rresp, rdata}, {1'b1, OKAY, old2});
    chk("coll_regs", 128'(regs), 128'(model_image()));
    rready = 1'b1;
    @(posedge clk);
    #1 rready = 1'b0;
    do_read(4'd8, 0, d, r, lat);
    chk("coll_reread", {r, d}, {OKAY, 32'hDEADBEEF});

    // Randomized traffic against the array model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(1) == 0) begin
        logic [IW-1:0] ri;
        logic [DW-1:0] rd;
        logic [3:0] re;
        ri = IW'($urandom_range(3));
        rd = $urandom;
        re = 4'($urandom_range(15));
        do_write(ri, rd, re);
        model_write(int'(ri), rd, re);
        chk("rand_write", 128'(regs), 128'(model_image()));
      end else begin
        int ri;
        ri = $urandom_range(3);
        do_read(AW'(ri * 4), $urandom_range(3), d, r, lat);
        if (ri < int'(DEPTH)) chk("rand_read", {32'(lat), r, d}, {32'd2, OKAY, model[ri]});
        else chk("rand_read_oor", {32'(lat), r, d}, {32'd2, DECERR, 32'h0});
      end
    end

    // Reset while R valid is pending
    @(negedge clk);
    ar_addr = 4'd4; ar_valid = 1'b1; rready = 1'b0;
    @(posedge clk);
    #1 ar_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 128'(rvalid), 128'(1));
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {rvalid, ar_ready, rresp, rdata}, '0);
    chk("midrst_regs", 128'(regs), '0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) model[k] = '0;
    @(negedge clk);
    chk("ready_after_midrst", {ar_ready, rvalid}, {1'b1, 1'b0});
    do_read(4'd4, 0, d, r, lat);
    chk("read_after_rst", {r, d}, {OKAY, 32'h0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
